// File: rtl/score_hex_driver_pkg.sv
// Shared definitions for the score-to-7-segment driver.
//   state_t    : conversion FSM encoding (IDLE, LOAD, SHIFT, COMMIT)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_TABLE  : active-low segment patterns for decimal digits 0-9, bit 0 = segment a
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed table, highest index first: entry [d] is the pattern for digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/score_hex_driver_if.sv
// Score/display bundle between the game core (master) and the HEX driver (slave).
//   score_p, score_o : binary scores from the game core
//   HEX0..HEX5       : active-low segment patterns (HEX2..0 player, HEX5..3 opponent)
//   busy             : conversion in flight
//   upd_pulse        : one-cycle pulse when a channel's HEX registers are written
//   sat_p, sat_o     : displayed value is saturated at the display maximum
interface score_hex_if #(
    parameter int W = 10
);
    logic [W-1:0] score_p;
    logic [W-1:0] score_o;
    logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic         busy;
    logic         upd_pulse;
    logic         sat_p;
    logic         sat_o;

    modport master (
        output score_p, score_o,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, upd_pulse, sat_p, sat_o
    );

    modport slave (
        input  score_p, score_o,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, upd_pulse, sat_p, sat_o
    );
endinterface

// File: rtl/score_hex_driver_seg7_digit.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   i_nib   : BCD digit (10-15 decode to blank)
//   i_blank : force all segments off
//   o_seg   : segment pattern, bit 0 = segment a
module seg7_digit
    import score_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank && (i_nib <= 4'd9))
            o_seg = SEG_TABLE[i_nib];
    end
endmodule

// File: rtl/score_hex_driver.sv
// Registered score display driver. Each score channel is converted to three BCD
// digits with a serial double-dabble engine (one bit per clock) shared between
// the player and opponent channels, then decoded into that channel's HEX regs.
//   VGA_CLK : game clock
//   reset_n : asynchronous active-low reset
//   bus     : score_hex_if slave (scores in; HEX0..5, busy, upd_pulse, sat_p/sat_o out)
module score_hex_driver
    import score_pkg::*;
#(
    parameter int W             = 10,
    parameter int MAX_SHOWN     = 999,
    parameter int BLANK_LEADING = 1
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    score_hex_if.slave  bus
);
    localparam int         CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [6:0] LEAD_RST = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_TABLE[0];

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    state_t          r_state;
    logic            r_sel_o;
    logic [W-1:0]    r_shadow_p, r_shadow_o;
    logic [CW-1:0]   r_cnt;
    logic            r_clamp;
    logic            r_busy, r_upd, r_sat_p, r_sat_o;
    logic [6:0]      r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
    logic [W-1:0]    r_snap;   // clamped value, shifted out MSB first
    logic [W-1:0]    r_raw;    // unclamped value, becomes the shadow on commit
    logic [11:0]     r_bcd;

    logic [W-1:0]    w_sel_score, w_clamped;
    logic            w_over;
    logic [11:0]     w_adj;
    logic            w_blank_h, w_blank_t;
    logic [6:0]      w_seg_h, w_seg_t, w_seg_u;

    assign w_sel_score = r_sel_o ? bus.score_o : bus.score_p;
    assign w_over      = int'(w_sel_score) > MAX_SHOWN;
    assign w_clamped   = w_over ? W'(MAX_SHOWN) : w_sel_score;
    assign w_adj       = {dd_adj(r_bcd[11:8]), dd_adj(r_bcd[7:4]), dd_adj(r_bcd[3:0])};

    // Tens is only blanked when hundreds is blanked too, so "105" keeps its 0.
    assign w_blank_h = (BLANK_LEADING != 0) && (r_bcd[11:8] == 4'd0);
    assign w_blank_t = w_blank_h && (r_bcd[7:4] == 4'd0);

    seg7_digit u_dig_h (.i_nib(r_bcd[11:8]), .i_blank(w_blank_h), .o_seg(w_seg_h));
    seg7_digit u_dig_t (.i_nib(r_bcd[7:4]),  .i_blank(w_blank_t), .o_seg(w_seg_t));
    seg7_digit u_dig_u (.i_nib(r_bcd[3:0]),  .i_blank(1'b0),      .o_seg(w_seg_u));

    // Datapath: no reset needed, every conversion starts from LOAD.
    always_ff @(posedge VGA_CLK) begin
        case (r_state)
            ST_LOAD: begin
                r_raw  <= w_sel_score;
                r_snap <= w_clamped;
                r_bcd  <= '0;
            end
            ST_SHIFT: begin
                r_bcd  <= 12'({w_adj, r_snap[W-1]});
                r_snap <= r_snap << 1;
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sel_o    <= 1'b0;
            r_shadow_p <= '0;
            r_shadow_o <= '0;
            r_cnt      <= '0;
            r_clamp    <= 1'b0;
            r_busy     <= 1'b0;
            r_upd      <= 1'b0;
            r_sat_p    <= 1'b0;
            r_sat_o    <= 1'b0;
            r_hex0     <= SEG_TABLE[0];
            r_hex1     <= LEAD_RST;
            r_hex2     <= LEAD_RST;
            r_hex3     <= SEG_TABLE[0];
            r_hex4     <= LEAD_RST;
            r_hex5     <= LEAD_RST;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Player wins ties.
                    if (bus.score_p != r_shadow_p) begin
                        r_sel_o <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end else if (bus.score_o != r_shadow_o) begin
                        r_sel_o <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= CW'(W - 1);
                    r_clamp <= w_over;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_cnt == '0)
                        r_state <= ST_COMMIT;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                ST_COMMIT: begin
                    r_upd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_sel_o) begin
                        r_hex3     <= w_seg_u;
                        r_hex4     <= w_seg_t;
                        r_hex5     <= w_seg_h;
                        r_shadow_o <= r_raw;
                        r_sat_o    <= r_clamp;
                    end else begin
                        r_hex0     <= w_seg_u;
                        r_hex1     <= w_seg_t;
                        r_hex2     <= w_seg_h;
                        r_shadow_p <= r_raw;
                        r_sat_p    <= r_clamp;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.HEX0      = r_hex0;
    assign bus.HEX1      = r_hex1;
    assign bus.HEX2      = r_hex2;
    assign bus.HEX3      = r_hex3;
    assign bus.HEX4      = r_hex4;
    assign bus.HEX5      = r_hex5;
    assign bus.busy      = r_busy;
    assign bus.upd_pulse = r_upd;
    assign bus.sat_p     = r_sat_p;
    assign bus.sat_o     = r_sat_o;
endmodule
